// File: rtl/pow2_check_arbiter_if.sv
// ---------------------------------------------------------------------------
// pow2_check_arbiter_if
// Bundles the two requester channels, the shared result/acknowledge return
// and the hit counters for pow2_check_arbiter.
//
//   req0/data0, req1/data1 : requester operands with level requests
//   ack0/ack1              : one-cycle result-valid pulses per requester
//   result                 : 1 = granted operand has exactly one bit set
//   busy                   : arbiter is in a transaction
//   hit_cnt0/hit_cnt1      : saturating power-of-two hit counts
//
// master : the operand sources (drive requests, observe results)
// slave  : the arbiter
// ---------------------------------------------------------------------------
interface pow2_check_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0;
  logic [3:0]       data0;
  logic             req1;
  logic [3:0]       data1;
  logic             ack0;
  logic             ack1;
  logic             result;
  logic             busy;
  logic [CNT_W-1:0] hit_cnt0;
  logic [CNT_W-1:0] hit_cnt1;

  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, result, busy, hit_cnt0, hit_cnt1
  );

  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, result, busy, hit_cnt0, hit_cnt1
  );
endinterface

// File: rtl/pow2_check_arbiter.sv
// ---------------------------------------------------------------------------
// pow2_check_arbiter
// Shares a single 4-bit is-power-of-two checker between two requesters.
// Requests are arbitrated round-robin, the granted operand is latched and
// pushed through the checker, and a registered result is returned with a
// one-cycle acknowledge to the owner. Per-requester hit counters saturate.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pow2_check_arbiter_if.slave (requests, operands, acks, result,
//          busy, hit counters)
//
// Parameters:
//   CNT_W : hit counter width (2 or more)
//
// State table:
//   state | meaning
//   IDLE  | waiting for a request; grant and latch operand on a request
//   CHECK | operand register drives the checker; result is captured
//   RESP  | ack to owner for this cycle; hit counter updated on exit
//
// Timing: request seen in IDLE at cycle T -> ack during T+2; next grant can
// be made at T+3.
// ---------------------------------------------------------------------------
module pow2_check_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pow2_check_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       operand_q;
  logic             owner_q;
  logic             last_q;
  logic             result_q;
  logic [CNT_W-1:0] hit_cnt0_q;
  logic [CNT_W-1:0] hit_cnt1_q;

  logic             grant_vld;
  logic             grant_sel;

  // Shared checker (I -> Y): true when exactly one bit of I is set.
  logic [3:0]       chk_i;
  logic             chk_y;

  assign chk_i = operand_q;
  assign chk_y = (chk_i != 4'd0) && ((chk_i & (chk_i - 4'd1)) == 4'd0);

  // Next-state and grant decision.
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          // Contention: the requester not served last wins.
          grant_vld = 1'b1;
          grant_sel = ~last_q;
        end else if (bus.req0) begin
          grant_vld = 1'b1;
          grant_sel = 1'b0;
        end else if (bus.req1) begin
          grant_vld = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant_vld) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant bookkeeping and operand capture.
  // last_q resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q <= 4'd0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
    end else if (grant_vld) begin
      operand_q <= grant_sel ? bus.data1 : bus.data0;
      owner_q   <= grant_sel;
      last_q    <= grant_sel;
    end
  end

  // Result register: captured only while the operand is being checked.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 1'b0;
    end else if (state_q == CHECK) begin
      result_q <= chk_y;
    end
  end

  // Saturating hit counters, updated on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt0_q <= '0;
      hit_cnt1_q <= '0;
    end else if ((state_q == RESP) && result_q) begin
      if (!owner_q && (hit_cnt0_q != CNT_MAX)) begin
        hit_cnt0_q <= hit_cnt0_q + CNT_ONE;
      end
      if (owner_q && (hit_cnt1_q != CNT_MAX)) begin
        hit_cnt1_q <= hit_cnt1_q + CNT_ONE;
      end
    end
  end

  // Outputs are decoded from registered state only.
  assign bus.ack0     = (state_q == RESP) && !owner_q;
  assign bus.ack1     = (state_q == RESP) &&  owner_q;
  assign bus.result   = result_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.hit_cnt0 = hit_cnt0_q;
  assign bus.hit_cnt1 = hit_cnt1_q;

endmodule

// File: tb/tb_pow2_check_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pow2_check_arbiter
// Self-checking bench for pow2_check_arbiter (CNT_W = 2 so saturation is
// reachable). Directed vector table, hand-written multi-cycle sequences and
// a randomized run against a cycle-scheduled transaction model.
// ---------------------------------------------------------------------------
module tb_pow2_check_arbiter;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int NRAND   = 300;
  localparam int NSLOT   = NRAND + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pow2_check_arbiter_if #(.CNT_W(CNT_W)) bus ();

  pow2_check_arbiter #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         sel;
    logic [3:0] data;
    bit         exp_res;
    int         exp_cnt0;
    int         exp_cnt1;
  } vec_t;

  vec_t vecs[8];

  // Expected per-cycle behaviour for the random run.
  bit e_ack0 [NSLOT];
  bit e_ack1 [NSLOT];
  bit e_res  [NSLOT];
  bit e_busy [NSLOT];
  bit e_inc0 [NSLOT];
  bit e_inc1 [NSLOT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_pow2(input logic [3:0] d);
    return $countones(d) == 1;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = 4'd0;
    bus.data1 = 4'd0;
    tick();
    tick();
    check("reset_busy",   bus.busy,     0);
    check("reset_ack0",   bus.ack0,     0);
    check("reset_ack1",   bus.ack1,     0);
    check("reset_result", bus.result,   0);
    check("reset_cnt0",   bus.hit_cnt0, 0);
    check("reset_cnt1",   bus.hit_cnt1, 0);
    rst = 1'b0;
  endtask

  // One isolated transaction from the current IDLE cycle. Returns with the
  // bench sitting in the IDLE cycle after the ack, requests dropped.
  task automatic run_txn(input bit sel, input logic [3:0] d, input bit exp_res, input string tag);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    if (sel) begin
      bus.req1  = 1'b1;
      bus.data1 = d;
    end else begin
      bus.req0  = 1'b1;
      bus.data0 = d;
    end
    for (int k = 1; k <= 6 && !seen; k++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check($sformatf("%s_latency", tag), lat, 2);
    if (seen) begin
      check($sformatf("%s_ack0", tag),   bus.ack0,   {31'd0, !sel});
      check($sformatf("%s_ack1", tag),   bus.ack1,   {31'd0, sel});
      check($sformatf("%s_result", tag), bus.result, {31'd0, exp_res});
    end
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check($sformatf("%s_busy_after", tag), bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw0, saw1, last, g;
    int free_at, m_cnt0, m_cnt1;

    vecs[0] = '{1'b1, 4'b0010, 1'b1, 0, 1};
    vecs[1] = '{1'b1, 4'b1010, 1'b0, 0, 1};
    vecs[2] = '{1'b1, 4'b1001, 1'b0, 0, 1};
    vecs[3] = '{1'b1, 4'b0000, 1'b0, 0, 1};
    vecs[4] = '{1'b0, 4'b1000, 1'b1, 1, 1};
    vecs[5] = '{1'b0, 4'b0111, 1'b0, 1, 1};
    vecs[6] = '{1'b1, 4'b0001, 1'b1, 1, 2};
    vecs[7] = '{1'b0, 4'b1111, 1'b0, 1, 2};

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].sel, vecs[i].data, vecs[i].exp_res, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_cnt0", i), bus.hit_cnt0, vecs[i].exp_cnt0);
      check($sformatf("vec%0d_cnt1", i), bus.hit_cnt1, vecs[i].exp_cnt1);
    end

    // Simultaneous requests held: 0, 1, 0 in strict alternation.
    do_reset();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.data0 = 4'b0001;
    bus.data1 = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      check($sformatf("rr_c%0d_ack0", c), bus.ack0, {31'd0, (c == 2) || (c == 8)});
      check($sformatf("rr_c%0d_ack1", c), bus.ack1, {31'd0, (c == 5)});
      if (c == 2 || c == 8) check($sformatf("rr_c%0d_result", c), bus.result, 1);
      if (c == 5)           check($sformatf("rr_c%0d_result", c), bus.result, 0);
      tick();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Saturation of a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, 4'b0100, 1'b1, $sformatf("sat%0d", i));
      check($sformatf("sat%0d_cnt0", i), bus.hit_cnt0, (i + 1 < CNT_MAX) ? i + 1 : CNT_MAX);
    end

    // Reset during CHECK abandons the transaction and restores priority.
    do_reset();
    bus.req0  = 1'b1;
    bus.data0 = 4'b0001;
    tick();
    check("midrst_in_check", bus.busy, 1);
    rst = 1'b1;
    tick();
    check("midrst_ack0", bus.ack0,     0);
    check("midrst_busy", bus.busy,     0);
    check("midrst_cnt0", bus.hit_cnt0, 0);
    check("midrst_cnt1", bus.hit_cnt1, 0);
    rst       = 1'b0;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.data0 = 4'b0010;
    bus.data1 = 4'b0001;
    tick();
    tick();
    check("midrst_next_ack0", bus.ack0,   1);
    check("midrst_next_ack1", bus.ack1,   0);
    check("midrst_next_res",  bus.result, 1);
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("midrst_next_cnt0", bus.hit_cnt0, 1);
    check("midrst_next_cnt1", bus.hit_cnt1, 0);

    // Back-to-back on requester 0.
    do_reset();
    bus.req0  = 1'b1;
    bus.data0 = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("b2b_c%0d_ack0", c), bus.ack0, {31'd0, (c % 3) == 2});
      check($sformatf("b2b_c%0d_ack1", c), bus.ack1, 0);
      check($sformatf("b2b_c%0d_busy", c), bus.busy, {31'd0, (c % 3) != 0});
      tick();
    end
    bus.req0 = 1'b0;

    // Randomized run against a transaction-scheduling model.
    do_reset();
    for (int i = 0; i < NSLOT; i++) begin
      e_ack0[i] = 1'b0;
      e_ack1[i] = 1'b0;
      e_res[i]  = 1'b0;
      e_busy[i] = 1'b0;
      e_inc0[i] = 1'b0;
      e_inc1[i] = 1'b0;
    end
    saw0    = 1'b0;
    saw1    = 1'b0;
    last    = 1'b1;
    free_at = 0;
    m_cnt0  = 0;
    m_cnt1  = 0;
    for (int c = 0; c < NRAND; c++) begin
      if (e_inc0[c] && m_cnt0 < CNT_MAX) m_cnt0++;
      if (e_inc1[c] && m_cnt1 < CNT_MAX) m_cnt1++;

      check($sformatf("rnd_c%0d_ack0", c), bus.ack0,     {31'd0, e_ack0[c]});
      check($sformatf("rnd_c%0d_ack1", c), bus.ack1,     {31'd0, e_ack1[c]});
      check($sformatf("rnd_c%0d_busy", c), bus.busy,     {31'd0, e_busy[c]});
      if (e_ack0[c] || e_ack1[c])
        check($sformatf("rnd_c%0d_result", c), bus.result, {31'd0, e_res[c]});
      check($sformatf("rnd_c%0d_cnt0", c), bus.hit_cnt0, m_cnt0);
      check($sformatf("rnd_c%0d_cnt1", c), bus.hit_cnt1, m_cnt1);

      // Requester 0 behaviour.
      if (bus.req0) begin
        if (saw0) begin
          if ($urandom_range(0, 1) == 0) bus.req0 = 1'b0;
          else bus.data0 = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.req0  = 1'b1;
        bus.data0 = 4'($urandom_range(0, 15));
      end else begin
        bus.data0 = 4'($urandom_range(0, 15));
      end
      // Requester 1 behaviour.
      if (bus.req1) begin
        if (saw1) begin
          if ($urandom_range(0, 1) == 0) bus.req1 = 1'b0;
          else bus.data1 = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.req1  = 1'b1;
        bus.data1 = 4'($urandom_range(0, 15));
      end else begin
        bus.data1 = 4'($urandom_range(0, 15));
      end
      saw0 = bus.ack0;
      saw1 = bus.ack1;

      // Model: a free arbiter takes one request and books the next 3 cycles.
      if (c >= free_at && (bus.req0 || bus.req1)) begin
        g    = (bus.req0 && bus.req1) ? !last : bus.req1;
        last = g;
        e_busy[c + 1] = 1'b1;
        e_busy[c + 2] = 1'b1;
        if (g) e_ack1[c + 2] = 1'b1;
        else   e_ack0[c + 2] = 1'b1;
        e_res[c + 2] = ref_pow2(g ? bus.data1 : bus.data0);
        if (e_res[c + 2]) begin
          if (g) e_inc1[c + 3] = 1'b1;
          else   e_inc0[c + 3] = 1'b1;
        end
        free_at = c + 3;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pow2_check_arbiter.md
Name: pow2_check_arbiter

Overview:
- Shares one 4-bit is_power_of_2 checker (ports I, Y) between two requesters.
- Each requester presents a 4-bit operand with a request. The block arbitrates round-robin, sequences the operand through the checker and returns a registered one-bit result with an acknowledge.
- Keeps a saturating per-requester count of power-of-two hits.
- Sits between the lab's operand sources (switch/stimulus logic) and the shared checker.

Parameters:
CNT_W, 8, width of each hit counter; minimum 2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req0  in  1  requester 0 request; held high until ack0 is seen.
data0  in  4  requester 0 operand; stable while req0 is high.
req1  in  1  requester 1 request; same rules as req0.
data1  in  4  requester 1 operand.
ack0  out  1  one-cycle pulse: result is valid for requester 0.
ack1  out  1  one-cycle pulse: result is valid for requester 1.
result  out  1  1 = granted operand is a power of two; meaningful only while ack0 or ack1 is high.
busy  out  1  1 whenever state is not IDLE.
hit_cnt0  out  CNT_W  number of requester 0 transactions with result=1; saturating.
hit_cnt1  out  CNT_W  same, for requester 1.

Behaviour:
- Reset values (rst high at a rising edge):
  - state=IDLE.
  - ack0, ack1, result, busy = 0.
  - hit_cnt0, hit_cnt1 = 0.
  - Operand register = 0.
  - Round-robin pointer selects requester 0 first.
  - rst overrides every other input. Reset mid-transaction abandons it: no ack is produced and no counter is updated.
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - Neither req high: stay in IDLE.
  - Only one req high: grant that requester.
  - Both high: grant the requester not granted last. The pointer toggles only on a grant.
  - On a grant: latch the granted data into the operand register, record the owner, advance to CHECK.
- CHECK:
  - The operand register drives checker input I.
  - Checker output Y is registered into a result register.
  - Advance to RESP.
  - The requests are not sampled in this state.
- RESP:
  - Assert ack[owner]=1 for exactly this cycle; result holds the registered Y.
  - If Y=1, increment hit_cnt[owner] unless it is at all-ones (saturate, no wrap). The counter shows the new value from the next cycle.
  - Return to IDLE.
- Latency: req sampled in IDLE at cycle T; ack/result asserted during cycle T+2. One transaction every 3 cycles at most.
- The requester deasserts req in the cycle after it sees ack. If req is still high in that IDLE cycle, it is treated as a new request (back-to-back is legal).
- Operand 0000 is not a power of two (result=0). Exactly one set bit gives result=1.
- The ack not belonging to the owner stays 0. ack0 and ack1 are never high together.
- busy is 1 in CHECK and RESP and 0 in IDLE, registered with the state.
- Changes to data or req of a non-granted requester during CHECK/RESP have no effect.

Test Plan:
- Single requester: req0=1, data0=1000 → ack0=1 at T+2 with result=1; hit_cnt0=1; ack1 stays 0.
- Operand sweep on requester 1: data1 = 0010, 1010, 1001, 0000 in turn → results 1, 0, 0, 0; hit_cnt1=1 after all four.
- Simultaneous requests after reset: req0=req1=1 held across two transactions → first ack0, then ack1. The next simultaneous round grants req0 again (strict alternation).
- Saturation with CNT_W=2: five req0 transactions with data0=0100 → hit_cnt0 reads 1, 2, 3, 3, 3.
- Reset mid-transaction: assert rst during CHECK with data0=0001 → no ack0 pulse; busy=0 and both counters 0 next cycle; next request after reset is granted to requester 0.
- Back-to-back: req0 held high with data0=0001 → ack0 every 3 cycles; busy drops to 0 only for the single IDLE cycle between transactions.
